// File: rtl/pdp8_pkg.sv
// Shared PDP-8 core definitions: word widths, fetch FSM states, reset PC.
package pdp8_pkg;

    localparam int unsigned ADDR_WIDTH = 12;
    localparam int unsigned DATA_WIDTH = 12;

    // PC value the fetch unit starts from after reset
    localparam logic [ADDR_WIDTH-1:0] START_ADDR_DEFAULT = 12'o0200;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } fetch_state_t;

endpackage

// File: rtl/pdp8_fetch_unit_if.sv
// Fetch unit bus bundle: memory read port plus the fetch-to-decode handshake.
// The master side is the fetch unit; the slave side is memory and decode.
interface pdp8_fetch_unit_if;
    import pdp8_pkg::*;

    logic                  ifu_rd_req;
    logic [ADDR_WIDTH-1:0] ifu_rd_addr;
    logic [DATA_WIDTH-1:0] ifu_rd_data;
    logic                  if_valid;
    logic [DATA_WIDTH-1:0] if_instr;
    logic [ADDR_WIDTH-1:0] if_pc;
    logic                  id_ready;

    modport master (
        output ifu_rd_req,
        output ifu_rd_addr,
        input  ifu_rd_data,
        output if_valid,
        output if_instr,
        output if_pc,
        input  id_ready
    );

    modport slave (
        input  ifu_rd_req,
        input  ifu_rd_addr,
        output ifu_rd_data,
        input  if_valid,
        input  if_instr,
        input  if_pc,
        output id_ready
    );

endinterface

// File: rtl/pdp8_fetch_unit.sv
// PDP-8 instruction fetch unit: owns the PC, issues one read at a time, waits a
// fixed latency for the data and holds the instruction until decode takes it.
module pdp8_fetch_unit
    import pdp8_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] START_ADDR = START_ADDR_DEFAULT,
    parameter int unsigned           RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ifu_start,
    input  logic                  ifu_halt,
    input  logic                  ex_redirect,
    input  logic [ADDR_WIDTH-1:0] ex_redirect_pc,
    pdp8_fetch_unit_if.master     bus
);

    localparam logic [2:0] LAT_INIT = 3'(RD_LATENCY);

    fetch_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  rd_req_q, rd_req_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [ADDR_WIDTH-1:0] if_pc_q, if_pc_d;
    logic                  squash_q, squash_d;
    logic [2:0]            lat_cnt_q, lat_cnt_d;
    logic                  go_req;

    // Next-state and registered-output logic for the fetch sequence
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        rd_req_d  = 1'b0;
        rd_addr_d = rd_addr_q;
        valid_d   = valid_q;
        instr_d   = instr_q;
        if_pc_d   = if_pc_q;
        squash_d  = squash_q;
        lat_cnt_d = lat_cnt_q;
        go_req    = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Halt wins over start; redirects are ignored while idle
                if (ifu_start && !ifu_halt) begin
                    go_req = 1'b1;
                end
            end
            REQ: begin
                lat_cnt_d = LAT_INIT;
                state_d   = WAIT;
                if (ex_redirect) begin
                    pc_d     = ex_redirect_pc;
                    squash_d = 1'b1;
                end
            end
            WAIT: begin
                lat_cnt_d = lat_cnt_q - 3'd1;
                if (lat_cnt_q == 3'd1) begin
                    // Capture edge; a redirect arriving right now also squashes
                    if (squash_q || ex_redirect) begin
                        squash_d = 1'b0;
                        if (ex_redirect) begin
                            pc_d = ex_redirect_pc;
                        end
                        if (ifu_halt) begin
                            state_d = IDLE;
                        end else begin
                            go_req = 1'b1;
                        end
                    end else begin
                        instr_d = bus.ifu_rd_data;
                        if_pc_d = pc_q;
                        valid_d = 1'b1;
                        pc_d    = pc_q + 12'd1;
                        state_d = HOLD;
                    end
                end else if (ex_redirect) begin
                    // Read keeps running to its capture edge to preserve spacing
                    pc_d     = ex_redirect_pc;
                    squash_d = 1'b1;
                end
            end
            HOLD: begin
                // Accept consumes the word; a redirect without accept drops it
                if ((bus.id_ready && valid_q) || ex_redirect) begin
                    valid_d = 1'b0;
                    if (ex_redirect) begin
                        pc_d = ex_redirect_pc;
                    end
                    if (ifu_halt) begin
                        state_d = IDLE;
                    end else begin
                        go_req = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Request issued from the final PC so a same-cycle redirect is honoured
        if (go_req) begin
            state_d   = REQ;
            rd_req_d  = 1'b1;
            rd_addr_d = pc_d;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            pc_q      <= START_ADDR;
            rd_req_q  <= 1'b0;
            rd_addr_q <= '0;
            valid_q   <= 1'b0;
            instr_q   <= '0;
            if_pc_q   <= '0;
            squash_q  <= 1'b0;
            lat_cnt_q <= 3'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            rd_req_q  <= rd_req_d;
            rd_addr_q <= rd_addr_d;
            valid_q   <= valid_d;
            instr_q   <= instr_d;
            if_pc_q   <= if_pc_d;
            squash_q  <= squash_d;
            lat_cnt_q <= lat_cnt_d;
        end
    end

    assign bus.ifu_rd_req  = rd_req_q;
    assign bus.ifu_rd_addr = rd_addr_q;
    assign bus.if_valid    = valid_q;
    assign bus.if_instr    = instr_q;
    assign bus.if_pc       = if_pc_q;

endmodule
